// File: rtl/meas_snapshot_tx_pkg.sv
`default_nettype none
//============================================================================
// Module   : meas_snapshot_tx_pkg
// Brief    : State encodings, window geometry and status-byte helper shared
//            by the measurement snapshot / transmit sequencer.
// Revision : 1.0 - initial release
//============================================================================
package meas_snapshot_tx_pkg;

    // Sequencer state encodings (also exported in the status byte)
    localparam logic [2:0] c_MS_IDLE   = 3'd0;
    localparam logic [2:0] c_MS_WAIT   = 3'd1;
    localparam logic [2:0] c_MS_SNAP   = 3'd2;
    localparam logic [2:0] c_MS_TXREQ  = 3'd3;
    localparam logic [2:0] c_MS_TXWAIT = 3'd4;

    // Register window length in bytes
    localparam int c_MS_LEN = 10;

    // Status byte bit positions
    localparam int c_STAT_VALID_BIT = 7;
    localparam int c_STAT_ERR_BIT   = 6;
    localparam int c_STAT_STATE_MSB = 2;

    typedef enum logic [2:0] {
        S_IDLE   = c_MS_IDLE,
        S_WAIT   = c_MS_WAIT,
        S_SNAP   = c_MS_SNAP,
        S_TXREQ  = c_MS_TXREQ,
        S_TXWAIT = c_MS_TXWAIT
    } ms_state_t;

    // Pack the status byte: {valid, err, 3'b0, state}
    function automatic logic [7:0] ms_status(input logic       valid,
                                             input logic       err,
                                             input logic [2:0] state);
        logic [7:0] v;
        v                        = 8'h00;
        v[c_STAT_VALID_BIT]      = valid;
        v[c_STAT_ERR_BIT]        = err;
        v[c_STAT_STATE_MSB:0]    = state;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/meas_snapshot_tx_tmo_cnt.sv
`default_nettype none
//============================================================================
// Module   : ms_tmo_cnt
// Brief    : ce10ms-gated timeout counter with synchronous clear. Saturates
//            at TMO_TICKS and raises a terminal flag while there.
// Revision : 1.0 - initial release
//============================================================================
module ms_tmo_cnt #(
    parameter int TMO_TICKS = 200,
    parameter int TMO_W     = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [TMO_W-1:0] c_TERM = TMO_W'(TMO_TICKS);

    logic [TMO_W-1:0] r_cnt;

    // Count enabled ticks, clear has priority, hold once terminal is reached
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != c_TERM)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tc = (r_cnt == c_TERM);

endmodule
`default_nettype wire

// File: rtl/meas_snapshot_tx.sv
`default_nettype none
//============================================================================
// Module   : meas_snapshot_tx
// Brief    : Collects both BIN->DEC conversion-done pulses after a measure
//            start, snapshots the results into a UART-readable shadow
//            window, then kicks a UART block transmit. Timeout guarded.
// Revision : 1.0 - initial release
//============================================================================
module meas_snapshot_tx
    import meas_snapshot_tx_pkg::*;
#(
    parameter logic [15:0] BASE_ADR  = 16'h0010,
    parameter int          TMO_TICKS = 200,
    parameter int          TMO_W     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce10ms,
    input  logic        st,
    input  logic        ok_q,
    input  logic        ok_f,
    input  logic [15:0] DEC_Q,
    input  logic [31:0] DEC_F,
    input  logic [15:0] BIN_Q,
    input  logic        tx_busy,
    input  logic [15:0] rd_adr,
    output logic        st_tx,
    output logic [7:0]  rd_dat,
    output logic        hit,
    output logic        busy
);

    ms_state_t   r_state;
    ms_state_t   w_state_nxt;

    logic        r_got_q;
    logic        r_got_f;
    logic        r_valid;
    logic        r_err;
    logic        r_seen_busy;
    logic        r_st_tx;
    logic [7:0]  r_seq;
    logic [15:0] r_dec_q;
    logic [31:0] r_dec_f;
    logic [15:0] r_bin_q;

    logic        w_clr_run;   // accepted st: clear flags, err and timer
    logic        w_snap;
    logic        w_set_err;
    logic        w_tx_go;
    logic        w_tmr_clr;
    logic        w_tmr_en;
    logic        w_tmo;

    logic [15:0] w_off;
    logic        w_hit;
    logic [7:0]  w_rd_dat;

    ms_tmo_cnt #(
        .TMO_TICKS (TMO_TICKS),
        .TMO_W     (TMO_W)
    ) u_tmo (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_tmr_clr),
        .i_en  (w_tmr_en),
        .o_tc  (w_tmo)
    );

    assign w_tmr_clr = w_clr_run | w_snap;
    assign w_tmr_en  = ce10ms & ((r_state == S_WAIT) | (r_state == S_TXWAIT));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and sequencing strobes
    always_comb begin
        w_state_nxt = r_state;
        w_clr_run   = 1'b0;
        w_snap      = 1'b0;
        w_set_err   = 1'b0;
        w_tx_go     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (st) begin
                    w_clr_run   = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // A fresh st restarts collection; it outranks completion
                if (st) begin
                    w_clr_run = 1'b1;
                end else if (r_got_q && r_got_f) begin
                    w_state_nxt = S_SNAP;
                end else if (w_tmo) begin
                    w_set_err   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_SNAP: begin
                w_snap      = 1'b1;
                w_state_nxt = S_TXREQ;
            end
            S_TXREQ: begin
                if (!tx_busy) begin
                    w_tx_go     = 1'b1;
                    w_state_nxt = S_TXWAIT;
                end
            end
            S_TXWAIT: begin
                if (r_seen_busy && !tx_busy) begin
                    w_state_nxt = S_IDLE;
                end else if (w_tmo) begin
                    w_set_err   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Conversion-done flags and error latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_got_q <= 1'b0;
            r_got_f <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_clr_run) begin
                r_got_q <= 1'b0;
                r_got_f <= 1'b0;
            end else if (r_state == S_WAIT) begin
                if (ok_q) r_got_q <= 1'b1;
                if (ok_f) r_got_f <= 1'b1;
            end
            if (w_clr_run) begin
                r_err <= 1'b0;
            end else if (w_set_err) begin
                r_err <= 1'b1;
            end
        end
    end

    // Transmit handshake: start pulse and observed-busy flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st_tx     <= 1'b0;
            r_seen_busy <= 1'b0;
        end else begin
            r_st_tx <= w_tx_go;
            if (w_tx_go) begin
                r_seen_busy <= 1'b0;
            end else if ((r_state == S_TXWAIT) && tx_busy) begin
                r_seen_busy <= 1'b1;
            end
        end
    end

    // Shadow window: only written in SNAP so UART reads stay coherent
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dec_q <= '0;
            r_dec_f <= '0;
            r_bin_q <= '0;
            r_seq   <= '0;
            r_valid <= 1'b0;
        end else if (w_snap) begin
            r_dec_q <= DEC_Q;
            r_dec_f <= DEC_F;
            r_bin_q <= BIN_Q;
            r_seq   <= r_seq + 8'd1;
            r_valid <= 1'b1;
        end
    end

    // Read window decode; unsigned wrap makes addresses below BASE miss
    assign w_off = rd_adr - BASE_ADR;
    assign w_hit = (w_off < 16'(c_MS_LEN));

    // Read data mux
    always_comb begin
        w_rd_dat = 8'h00;
        if (w_hit) begin
            case (w_off[3:0])
                4'd0:    w_rd_dat = ms_status(r_valid, r_err, r_state);
                4'd1:    w_rd_dat = r_seq;
                4'd2:    w_rd_dat = r_dec_q[15:8];
                4'd3:    w_rd_dat = r_dec_q[7:0];
                4'd4:    w_rd_dat = r_dec_f[31:24];
                4'd5:    w_rd_dat = r_dec_f[23:16];
                4'd6:    w_rd_dat = r_dec_f[15:8];
                4'd7:    w_rd_dat = r_dec_f[7:0];
                4'd8:    w_rd_dat = r_bin_q[15:8];
                4'd9:    w_rd_dat = r_bin_q[7:0];
                default: w_rd_dat = 8'h00;
            endcase
        end
    end

    assign st_tx  = r_st_tx;
    assign busy   = (r_state != S_IDLE);
    assign hit    = w_hit;
    assign rd_dat = w_rd_dat;

endmodule
`default_nettype wire

// File: tb/tb_meas_snapshot_tx.sv
`default_nettype none
`timescale 1ns/1ps
//============================================================================
// Module   : tb_meas_snapshot_tx
// Brief    : Randomized self-checking bench for meas_snapshot_tx with a
//            cycle-level behavioural reference model and literal checks.
// Revision : 1.0 - initial release
//============================================================================
module tb_meas_snapshot_tx;

    localparam logic [15:0] BASE = 16'h0010;
    localparam int          TMO  = 200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ce10ms = 1'b0;
    logic        st = 1'b0;
    logic        ok_q = 1'b0;
    logic        ok_f = 1'b0;
    logic [15:0] DEC_Q = '0;
    logic [31:0] DEC_F = '0;
    logic [15:0] BIN_Q = '0;
    logic        tx_busy = 1'b0;
    logic [15:0] rd_adr = '0;
    logic        st_tx;
    logic [7:0]  rd_dat;
    logic        hit;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // bench control
    int cyc = 0;
    int rd_fix = -1;
    bit data_fix = 1'b0;
    int uart_fix = 0;
    bit uart_mute = 1'b0;
    bit bp_hold = 1'b0;
    int ub_dly = 0;
    int ub_len = 0;
    int n_sttx = 0;
    int n_tick = 0;
    int t_ok_edge = 0;
    int exp_seq = 0;

    meas_snapshot_tx dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ce10ms  (ce10ms),
        .st      (st),
        .ok_q    (ok_q),
        .ok_f    (ok_f),
        .DEC_Q   (DEC_Q),
        .DEC_F   (DEC_F),
        .BIN_Q   (BIN_Q),
        .tx_busy (tx_busy),
        .rd_adr  (rd_adr),
        .st_tx   (st_tx),
        .rd_dat  (rd_dat),
        .hit     (hit),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // ---------------- behavioural reference model ----------------
    // phase numbering follows the order the states are listed: 0 idle,
    // 1 wait, 2 snap, 3 txreq, 4 txwait
    int          m_ph = 0;
    bit          m_gq, m_gf, m_err, m_valid, m_seen, m_sttx;
    int          m_tmr = 0;
    int          m_seq = 0;
    logic [15:0] m_dq = '0, m_bq = '0;
    logic [31:0] m_df = '0;

    task automatic mdl_reset();
        m_ph = 0; m_gq = 0; m_gf = 0; m_err = 0; m_valid = 0; m_seen = 0;
        m_sttx = 0; m_tmr = 0; m_seq = 0; m_dq = '0; m_bq = '0; m_df = '0;
    endtask

    task automatic mdl_step();
        m_sttx = 0;
        case (m_ph)
            0: if (st) begin
                m_ph = 1; m_gq = 0; m_gf = 0; m_err = 0; m_tmr = 0;
            end
            1: begin
                if (st) begin
                    m_gq = 0; m_gf = 0; m_tmr = 0;
                end else if (m_gq && m_gf) begin
                    m_ph = 2;
                end else if (m_tmr >= TMO) begin
                    m_err = 1; m_ph = 0;
                end else begin
                    if (ok_q) m_gq = 1;
                    if (ok_f) m_gf = 1;
                    if (ce10ms) m_tmr++;
                end
            end
            2: begin
                m_dq = DEC_Q; m_df = DEC_F; m_bq = BIN_Q;
                m_seq = (m_seq + 1) % 256;
                m_valid = 1; m_tmr = 0; m_ph = 3;
            end
            3: if (!tx_busy) begin
                m_sttx = 1; m_seen = 0; m_ph = 4;
            end
            4: begin
                if (m_seen && !tx_busy) begin
                    m_ph = 0;
                end else if (m_tmr >= TMO) begin
                    m_err = 1; m_ph = 0;
                end else begin
                    if (tx_busy) m_seen = 1;
                    if (ce10ms) m_tmr++;
                end
            end
            default: m_ph = 0;
        endcase
    endtask

    function automatic bit mdl_hit(input logic [15:0] a);
        int off;
        off = int'(a) - int'(BASE);
        return (off >= 0) && (off <= 9);
    endfunction

    function automatic logic [7:0] mdl_byte(input logic [15:0] a);
        int off;
        off = int'(a) - int'(BASE);
        case (off)
            0: return (m_valid ? 8'h80 : 8'h00) | (m_err ? 8'h40 : 8'h00) | 8'(m_ph);
            1: return 8'(m_seq);
            2: return 8'(m_dq >> 8);
            3: return 8'(m_dq);
            4: return 8'(m_df >> 24);
            5: return 8'(m_df >> 16);
            6: return 8'(m_df >> 8);
            7: return 8'(m_df);
            8: return 8'(m_bq >> 8);
            9: return 8'(m_bq);
            default: return 8'h00;
        endcase
    endfunction

    always @(negedge rst_n) mdl_reset();

    always @(posedge clk) begin
        if (!rst_n) mdl_reset();
        else        mdl_step();
    end

    // ---------------- checking ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("cyc_st_tx", {31'd0, st_tx}, {31'd0, m_sttx});
        check("cyc_busy", {31'd0, busy}, {31'd0, (m_ph != 0)});
        check("cyc_hit", {31'd0, hit}, {31'd0, mdl_hit(rd_adr)});
        check("cyc_rd_dat", {24'd0, rd_dat}, {24'd0, mdl_byte(rd_adr)});
    end

    always @(negedge clk) if (st_tx === 1'b1) n_sttx++;
    always @(posedge clk) if (ce10ms && busy) n_tick++;

    // ---------------- stimulus drivers ----------------
    always @(posedge clk) begin
        #1;
        ce10ms = ($urandom_range(0, 3) == 0);
    end

    always @(posedge clk) begin
        #1;
        if (!data_fix) begin
            DEC_Q = 16'($urandom);
            DEC_F = $urandom;
            BIN_Q = 16'($urandom);
        end
    end

    always @(posedge clk) begin
        #1;
        if (rd_fix < 0) rd_adr = 16'($urandom_range(int'(BASE) - 2, int'(BASE) + 11));
        else            rd_adr = 16'(rd_fix);
    end

    // simple UART: after st_tx goes busy for a while (unless muted)
    always @(posedge clk) begin
        #1;
        if (bp_hold) begin
            tx_busy = 1'b1;
        end else begin
            if (st_tx === 1'b1 && !uart_mute) begin
                ub_dly = (uart_fix > 0) ? 0 : int'($urandom_range(0, 4));
                ub_len = (uart_fix > 0) ? uart_fix : int'($urandom_range(3, 60));
            end
            if (ub_dly > 0) begin
                ub_dly--; tx_busy = 1'b0;
            end else if (ub_len > 0) begin
                ub_len--; tx_busy = 1'b1;
            end else begin
                tx_busy = 1'b0;
            end
        end
    end

    task automatic pulse_st();
        @(posedge clk); #1 st = 1'b1;
        @(posedge clk); #1 st = 1'b0;
    endtask

    task automatic pulse_ok(input bit q, input bit f);
        @(posedge clk); #1;
        ok_q = q; ok_f = f; t_ok_edge = cyc + 1;
        @(posedge clk); #1;
        ok_q = 1'b0; ok_f = 1'b0;
    endtask

    task automatic wait_sttx(input int budget, input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (st_tx !== 1'b1 && n < budget) begin
            @(negedge clk); n++;
        end
        check(nm, {31'd0, st_tx}, 32'd1);
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk); n++;
        end
        check(nm, {31'd0, busy}, 32'd0);
    endtask

    task automatic read_chk(input int adr, input logic [7:0] d, input bit h, input string nm);
        rd_fix = adr;
        @(posedge clk); #2;
        check({nm, "_dat"}, {24'd0, rd_dat}, {24'd0, d});
        check({nm, "_hit"}, {31'd0, hit}, {31'd0, h});
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "bench watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin : main
        int n0;
        int t_rel;
        int kind;
        bit first;
        logic [7:0] sv_b [1:9];

        // reset state
        repeat (3) @(posedge clk);
        #2;
        check("rst_st_tx", {31'd0, st_tx}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        read_chk(int'(BASE), 8'h00, 1'b1, "rst_status");
        @(posedge clk); #1 rst_n = 1'b1;
        rd_fix = -1;

        // normal run
        data_fix = 1'b1;
        DEC_Q = 16'h1234; DEC_F = 32'h00501234; BIN_Q = 16'h04D2;
        uart_fix = 50;
        n0 = n_sttx;
        pulse_st();
        repeat (98) @(posedge clk);
        pulse_ok(1'b1, 1'b0);
        repeat (198) @(posedge clk);
        pulse_ok(1'b0, 1'b1);
        wait_sttx(10, "norm_sttx_seen");
        check("norm_sttx_latency", 32'(cyc - t_ok_edge), 32'd3);
        data_fix = 1'b0;
        wait_idle(200, "norm_idle");
        exp_seq = 1;
        check("norm_single_sttx", 32'(n_sttx - n0), 32'd1);
        read_chk(int'(BASE) + 0, 8'h80, 1'b1, "norm_status");
        read_chk(int'(BASE) + 1, 8'h01, 1'b1, "norm_seq");
        read_chk(int'(BASE) + 2, 8'h12, 1'b1, "norm_b2");
        read_chk(int'(BASE) + 3, 8'h34, 1'b1, "norm_b3");
        read_chk(int'(BASE) + 4, 8'h00, 1'b1, "norm_b4");
        read_chk(int'(BASE) + 5, 8'h50, 1'b1, "norm_b5");
        read_chk(int'(BASE) + 6, 8'h12, 1'b1, "norm_b6");
        read_chk(int'(BASE) + 7, 8'h34, 1'b1, "norm_b7");
        read_chk(int'(BASE) + 8, 8'h04, 1'b1, "norm_b8");
        read_chk(int'(BASE) + 9, 8'hD2, 1'b1, "norm_b9");
        rd_fix = -1;
        uart_fix = 0;

        // simultaneous ok pulses
        pulse_st();
        repeat (5) @(posedge clk);
        pulse_ok(1'b1, 1'b1);
        wait_sttx(10, "simul_sttx_seen");
        check("simul_sttx_latency", 32'(cyc - t_ok_edge), 32'd3);
        wait_idle(200, "simul_idle");
        exp_seq = 2;
        read_chk(int'(BASE) + 1, 8'h02, 1'b1, "simul_seq");
        rd_fix = -1;

        // timeout in WAIT: only ok_q arrives
        for (int k = 1; k <= 9; k++) sv_b[k] = mdl_byte(16'(int'(BASE) + k));
        n0 = n_sttx;
        n_tick = 0;
        pulse_st();
        pulse_ok(1'b1, 1'b0);
        wait_idle(3000, "tmo_idle");
        check("tmo_ticks_in_range", {31'd0, (n_tick >= TMO) && (n_tick <= TMO + 1)}, 32'd1);
        check("tmo_no_sttx", 32'(n_sttx - n0), 32'd0);
        read_chk(int'(BASE), 8'hC0, 1'b1, "tmo_status");
        for (int k = 1; k <= 9; k++) read_chk(int'(BASE) + k, sv_b[k], 1'b1, "tmo_shadow");
        rd_fix = -1;

        // timeout in TXWAIT: UART never reports busy
        uart_mute = 1'b1;
        pulse_st();
        pulse_ok(1'b1, 1'b1);
        wait_sttx(10, "txw_sttx_seen");
        wait_idle(3000, "txw_idle");
        exp_seq = 3;
        read_chk(int'(BASE), 8'hC0, 1'b1, "txw_status");
        read_chk(int'(BASE) + 1, 8'h03, 1'b1, "txw_seq");
        rd_fix = -1;
        uart_mute = 1'b0;

        // back-pressure in TXREQ, st pulse ignored
        bp_hold = 1'b1;
        n0 = n_sttx;
        pulse_st();
        pulse_ok(1'b1, 1'b1);
        repeat (500) @(posedge clk);
        pulse_st();
        repeat (500) @(posedge clk);
        check("bp_no_sttx", 32'(n_sttx - n0), 32'd0);
        read_chk(int'(BASE), 8'h83, 1'b1, "bp_status_txreq");
        rd_fix = -1;
        @(negedge clk);
        bp_hold = 1'b0;
        t_rel = cyc;
        wait_sttx(20, "bp_sttx_seen");
        check("bp_sttx_after_release", 32'(cyc - t_rel), 32'd2);
        wait_idle(200, "bp_idle");
        exp_seq = 4;
        check("bp_single_sttx", 32'(n_sttx - n0), 32'd1);
        read_chk(int'(BASE) + 1, 8'h04, 1'b1, "bp_seq");
        rd_fix = -1;

        // randomized runs until the sequence number wraps
        while (exp_seq < 256) begin
            kind = int'($urandom_range(0, 15));
            pulse_st();
            repeat ($urandom_range(0, 20)) @(posedge clk);
            if (kind == 0) begin
                first = 1'($urandom_range(0, 1));
                pulse_ok(first, !first);
                wait_idle(3000, "rnd_tmo_idle");
            end else begin
                if (kind == 1) begin
                    pulse_ok(1'b1, 1'b0);
                    repeat ($urandom_range(0, 10)) @(posedge clk);
                    pulse_st();
                    repeat ($urandom_range(0, 10)) @(posedge clk);
                end
                if (kind < 6) begin
                    pulse_ok(1'b1, 1'b1);
                end else begin
                    first = 1'($urandom_range(0, 1));
                    pulse_ok(first, !first);
                    repeat ($urandom_range(0, 30)) @(posedge clk);
                    pulse_ok(!first, first);
                end
                wait_idle(500, "rnd_run_idle");
                exp_seq++;
            end
        end
        read_chk(int'(BASE) + 1, 8'h00, 1'b1, "wrap_seq");
        read_chk(int'(BASE), 8'h80, 1'b1, "wrap_status");

        // asynchronous reset while in WAIT
        rd_fix = int'(BASE) + 1;
        pulse_st();
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_st_tx", {31'd0, st_tx}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_seq_now", {24'd0, rd_dat}, 32'd0);
        for (int k = 0; k <= 9; k++) read_chk(int'(BASE) + k, 8'h00, 1'b1, "arst_win");
        @(posedge clk); #1 rst_n = 1'b1;

        // window boundaries
        read_chk(int'(BASE) - 1, 8'h00, 1'b0, "win_below");
        read_chk(int'(BASE) + 10, 8'h00, 1'b0, "win_above");
        read_chk(int'(BASE) + 9, 8'h00, 1'b1, "win_last");
        rd_fix = -1;
        repeat (5) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
